// File: rtl/key_mmio_pkg.sv
// Shared constants and helpers for the KEY push-button MMIO peripheral.
// Register indices, bus widths and the press-count width live here.
package key_mmio_pkg;

  localparam int KEY_ADDR_W  = 3;
  localparam int KEY_DATA_W  = 32;
  localparam int KEY_COUNT_W = 16;

  typedef logic [KEY_ADDR_W-1:0]  key_addr_t;
  typedef logic [KEY_DATA_W-1:0]  key_data_t;
  typedef logic [KEY_COUNT_W-1:0] key_count_t;

  localparam key_addr_t KEY_REG_LEVEL    = 3'd0;
  localparam key_addr_t KEY_REG_PRESSED  = 3'd1;
  localparam key_addr_t KEY_REG_RELEASED = 3'd2;
  localparam key_addr_t KEY_REG_COUNT    = 3'd3;
  localparam key_addr_t KEY_REG_IRQ_MASK = 3'd4;

  localparam key_count_t KEY_COUNT_MAX = '1;

  function automatic logic [3:0] key_popcount(
    input logic [7:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_mmio_if.sv
// Processor-side register bus of the KEY peripheral.
// master = processor load/store path, slave = peripheral.
interface key_mmio_if;
  import key_mmio_pkg::*;

  logic      rd_en;
  logic      wr_en;
  key_addr_t addr;
  key_data_t wr_data;
  key_data_t rd_data;
  logic      rd_valid;
  logic      addr_err;

  modport master (
    output rd_en,
    output wr_en,
    output addr,
    output wr_data,
    input  rd_data,
    input  rd_valid,
    input  addr_err
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  addr,
    input  wr_data,
    output rd_data,
    output rd_valid,
    output addr_err
  );

endinterface

// File: rtl/key_mmio_peripheral_debounce.sv
// Per-key 2-flop synchronizer plus debounce counter and stable level.
// rise/fall pulse in the same cycle the stable level is updated.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_n;
  logic             sync_n;
  logic             sync;
  logic             hit;
  logic [CNT_W-1:0] cnt;

  assign sync = ~sync_n;
  assign hit  = (sync != stable) && (cnt == LAST);
  assign rise = hit & sync;
  assign fall = hit & ~sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_n <= 1'b1;
      sync_n <= 1'b1;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta_n <= key_n;
      sync_n <= meta_n;
      if (sync == stable) begin
        cnt <= '0;
      end else if (hit) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_mmio_peripheral.sv
// KEY push-button MMIO peripheral: debounced levels, W1C flags, press count.
// Define KEY_MMIO_IRQ_EN to enable IRQ_MASK and the irq output.
module key_mmio_peripheral
  import key_mmio_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  key_mmio_if.slave           bus,
  output logic                irq
);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] released;
  logic [NUM_KEYS-1:0] irq_mask;
  logic [NUM_KEYS-1:0] wr_bits;
  key_count_t          press_count;
  key_count_t          count_next;
  logic [KEY_COUNT_W:0] count_sum;
  logic [3:0]          n_rise;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[k]),
      .stable(level[k]),
      .rise  (rise[k]),
      .fall  (fall[k])
    );
  end

  logic sel_level;
  logic sel_pressed;
  logic sel_released;
  logic sel_count;
  logic sel_mask;
  logic mapped;

  assign sel_level    = bus.addr == KEY_REG_LEVEL;
  assign sel_pressed  = bus.addr == KEY_REG_PRESSED;
  assign sel_released = bus.addr == KEY_REG_RELEASED;
  assign sel_count    = bus.addr == KEY_REG_COUNT;
  assign sel_mask     = bus.addr == KEY_REG_IRQ_MASK;
  assign mapped       = bus.addr <= KEY_REG_IRQ_MASK;
  assign wr_bits      = bus.wr_data[NUM_KEYS-1:0];

  logic unused_wr;
  assign unused_wr = ^bus.wr_data[KEY_DATA_W-1:NUM_KEYS];

  // Clear-write and new presses in the same cycle: presses still count.
  assign n_rise = key_popcount(8'(rise));

  always_comb begin
    count_sum = '0;
    if (!(bus.wr_en && sel_count)) begin
      count_sum = {1'b0, press_count};
    end
    count_sum  = count_sum + (KEY_COUNT_W+1)'(n_rise);
    count_next = count_sum[KEY_COUNT_W] ? KEY_COUNT_MAX
                                        : count_sum[KEY_COUNT_W-1:0];
  end

  logic [NUM_KEYS-1:0] clr_pressed;
  logic [NUM_KEYS-1:0] clr_released;

  assign clr_pressed  = (bus.wr_en && sel_pressed)  ? wr_bits : '0;
  assign clr_released = (bus.wr_en && sel_released) ? wr_bits : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pressed     <= '0;
      released    <= '0;
      press_count <= '0;
    end else begin
      pressed     <= (pressed & ~clr_pressed) | rise;
      released    <= (released & ~clr_released) | fall;
      press_count <= count_next;
    end
  end

`ifdef KEY_MMIO_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (bus.wr_en && sel_mask) begin
        irq_mask <= wr_bits;
      end
      irq <= |(pressed & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  key_data_t rd_next;
  key_data_t rd_data_q;
  logic      rd_valid_q;
  logic      addr_err_q;

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      sel_level:    rd_next[NUM_KEYS-1:0]    = level;
      sel_pressed:  rd_next[NUM_KEYS-1:0]    = pressed;
      sel_released: rd_next[NUM_KEYS-1:0]    = released;
      sel_count:    rd_next[KEY_COUNT_W-1:0] = press_count;
      sel_mask:     rd_next[NUM_KEYS-1:0]    = irq_mask;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      addr_err_q <= (bus.rd_en | bus.wr_en) & ~mapped;
      if (bus.rd_en) begin
        rd_data_q <= rd_next;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_key_mmio_peripheral.sv
// Self-checking bench for key_mmio_peripheral (DEBOUNCE_CYCLES=4).
// Reference model: per-key sample windows and plain register arithmetic.
module tb_key_mmio_peripheral;
  import key_mmio_pkg::*;

  localparam int NK  = 4;
  localparam int DEB = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic          irq;

  key_mmio_if bus();

  key_mmio_peripheral #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_n),
    .bus  (bus),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [NK-1:0] raw_q[$];
  logic [NK-1:0] samp_q[$];
  logic [NK-1:0] m_level, m_pressed, m_released, m_mask, m_rise;
  int            m_count;
  logic          m_irq, m_valid, m_err;
  logic [31:0]   m_data;

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_level);
      3'd1: return 32'(m_pressed);
      3'd2: return 32'(m_released);
      3'd3: return 32'(m_count);
      3'd4: return 32'(m_mask);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    raw_q = {};
    raw_q.push_back('1);
    raw_q.push_back('1);
    samp_q = {};
    repeat (DEB) samp_q.push_back('0);
    m_level = '0; m_pressed = '0; m_released = '0;
    m_mask = '0; m_rise = '0; m_count = 0;
    m_irq = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_data = '0;
  endtask

  // A key's level flips once the last DEB synchronized samples all disagree.
  task automatic model_step();
    logic [NK-1:0] sync, fall, w;
    logic [31:0]   rv;
    logic          irq_n, all;
    int            c;
    if (!rst) begin
      model_reset();
      return;
    end
    rv = model_reg(bus.addr);
`ifdef KEY_MMIO_IRQ_EN
    irq_n = |(m_pressed & m_mask);
`else
    irq_n = 1'b0;
`endif
    sync = ~raw_q.pop_front();
    raw_q.push_back(key_n);
    void'(samp_q.pop_front());
    samp_q.push_back(sync);
    m_rise = '0;
    fall   = '0;
    for (int k = 0; k < NK; k++) begin
      all = 1'b1;
      foreach (samp_q[j]) if (samp_q[j][k] == m_level[k]) all = 1'b0;
      if (all) begin
        if (m_level[k]) fall[k] = 1'b1;
        else m_rise[k] = 1'b1;
      end
    end
    m_level = m_level ^ (m_rise | fall);
    w = bus.wr_data[NK-1:0];
    if (bus.wr_en && bus.addr == KEY_REG_PRESSED)  m_pressed  &= ~w;
    if (bus.wr_en && bus.addr == KEY_REG_RELEASED) m_released &= ~w;
    m_pressed  |= m_rise;
    m_released |= fall;
    c = (bus.wr_en && bus.addr == KEY_REG_COUNT) ? 0 : m_count;
    c += $countones(m_rise);
    if (c > 65535) c = 65535;
    m_count = c;
`ifdef KEY_MMIO_IRQ_EN
    if (bus.wr_en && bus.addr == KEY_REG_IRQ_MASK) m_mask = w;
`endif
    m_irq   = irq_n;
    m_valid = bus.rd_en;
    if (bus.rd_en) m_data = rv;
    m_err = (bus.rd_en || bus.wr_en) && (bus.addr > 3'd4);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d,
                         output logic v, output logic e);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    tick();
    d = bus.rd_data;
    v = bus.rd_valid;
    e = bus.addr_err;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] wd);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = wd;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic settle(input int n);
    key_n = '1;
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v, e;
    key_n = '0;
    rst   = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (irq !== 1'b0 || bus.rd_valid !== 1'b0 ||
          bus.rd_data !== 32'd0 || bus.addr_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs irq=%b valid=%b data=%h err=%b required all 0",
                 irq, bus.rd_valid, bus.rd_data, bus.addr_err);
      end
    end
    rst = 1'b1;
    do_read(KEY_REG_LEVEL, d, v, e);
    checks++;
    if (v !== 1'b1 || d !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_level_read valid=%b data=%h irq=%b required 1/0/0", v, d, irq);
    end
    key_n = '1;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_valid_once valid=%b data=%h required 0/0",
               bus.rd_valid, bus.rd_data);
    end
    settle(12);
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    logic v, e, bad;
    int first;
    apply_reset();
    settle(4);
    key_n[2] = 1'b0;
    repeat (3) tick();
    key_n[2] = 1'b1;
    repeat (10) tick();
    do_read(KEY_REG_LEVEL, d, v, e);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL glitch_level got=%h required 0", d);
    end
    do_read(KEY_REG_PRESSED, d, v, e);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL glitch_pressed got=%h required 0", d);
    end
    key_n[2] = 1'b0;
    first = 0;
    bad   = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.rd_en = 1'b1;
      bus.addr  = KEY_REG_LEVEL;
      tick();
      if (first == 0 && bus.rd_data[2] === 1'b1) first = i;
      if (bus.rd_data !== m_data) bad = 1'b1;
    end
    bus.rd_en = 1'b0;
    checks++;
    if (first != 7 || bad) begin
      failures++;
      $display("FAIL debounce_latency first_read=%0d required 7 (model_mismatch=%b)",
               first, bad);
    end
    do_read(KEY_REG_PRESSED, d, v, e);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL debounce_pressed got=%h required 4", d);
    end
    do_read(KEY_REG_COUNT, d, v, e);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL debounce_count got=%h required 1", d);
    end
    settle(10);
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    logic v, e;
    do_write(KEY_REG_PRESSED, 32'hF);
    key_n[0] = 1'b0;
    repeat (5) tick();
    bus.wr_en   = 1'b1;
    bus.addr    = KEY_REG_PRESSED;
    bus.wr_data = 32'h1;
    tick();
    bus.wr_en = 1'b0;
    do_read(KEY_REG_PRESSED, d, v, e);
    checks++;
    if (d[0] !== 1'b1 || d !== m_data) begin
      failures++;
      $display("FAIL w1c_race_set_wins got=%h required %h", d, m_data);
    end
    do_write(KEY_REG_PRESSED, 32'h1);
    do_read(KEY_REG_PRESSED, d, v, e);
    checks++;
    if (d[0] !== 1'b0 || d !== m_data) begin
      failures++;
      $display("FAIL w1c_clear got=%h required %h", d, m_data);
    end
    settle(10);
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic v, e;
    force dut.press_count = 16'hFFFE;
    #1;
    release dut.press_count;
    m_count = 32'hFFFE;
    do_read(KEY_REG_COUNT, d, v, e);
    checks++;
    if (d !== 32'hFFFE) begin
      failures++;
      $display("FAIL sat_preload got=%h required FFFE", d);
    end
    key_n = 4'b1100;
    repeat (10) tick();
    do_read(KEY_REG_COUNT, d, v, e);
    checks++;
    if (d !== 32'hFFFF || d !== m_data) begin
      failures++;
      $display("FAIL sat_two_rises got=%h required FFFF", d);
    end
    settle(10);
    key_n = 4'b1110;
    repeat (10) tick();
    do_read(KEY_REG_COUNT, d, v, e);
    checks++;
    if (d !== 32'hFFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h required FFFF", d);
    end
    do_write(KEY_REG_COUNT, $urandom);
    do_read(KEY_REG_COUNT, d, v, e);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL count_clear got=%h required 0", d);
    end
    settle(10);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic v, e;
    do_read(3'd6, d, v, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b1 || v !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_read data=%h err=%b valid=%b required 0/1/1", d, e, v);
    end
    tick();
    checks++;
    if (bus.addr_err !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_pulse err=%b required 0", bus.addr_err);
    end
    do_write(3'd7, $urandom);
    checks++;
    if (bus.addr_err !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_write err=%b required 1", bus.addr_err);
    end
    for (int a = 0; a < 5; a++) begin
      do_read(3'(a), d, v, e);
      checks++;
      if (d !== m_data || e !== 1'b0) begin
        failures++;
        $display("FAIL regs_after_unmapped addr=%0d got=%h err=%b required %h/0",
                 a, d, e, m_data);
      end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] held;
    key_n[1] = 1'b0;
    repeat (10) tick();
    settle(10);
    bus.rd_en   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.addr    = KEY_REG_PRESSED;
    bus.wr_data = 32'hF;
    tick();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    held = bus.rd_data;
    checks++;
    if (held[1] !== 1'b1 || held !== m_data) begin
      failures++;
      $display("FAIL rw_same_prewrite got=%h required %h", held, m_data);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== held) begin
      failures++;
      $display("FAIL rd_data_hold valid=%b data=%h required 0/%h",
               bus.rd_valid, bus.rd_data, held);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic v, e, bad;
    int set_at, irq_at;
    do_write(KEY_REG_PRESSED, 32'hF);
    do_write(KEY_REG_IRQ_MASK, 32'h8);
    key_n[3] = 1'b0;
    set_at = -1;
    irq_at = -1;
    bad    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (set_at < 0 && m_pressed[3]) set_at = i;
      if (irq_at < 0 && irq === 1'b1) irq_at = i;
      if (irq !== m_irq) bad = 1'b1;
    end
`ifdef KEY_MMIO_IRQ_EN
    checks++;
    if (set_at < 0 || irq_at != set_at + 1 || bad) begin
      failures++;
      $display("FAIL irq_assert irq_cycle=%0d required %0d", irq_at, set_at + 1);
    end
    do_write(KEY_REG_PRESSED, 32'h8);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear irq=%b required 0", irq);
    end
`else
    checks++;
    if (irq_at != -1 || bad) begin
      failures++;
      $display("FAIL irq_disabled irq_cycle=%0d required none", irq_at);
    end
    do_read(KEY_REG_IRQ_MASK, d, v, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL mask_disabled data=%h err=%b required 0/0", d, e);
    end
`endif
    do_write(KEY_REG_IRQ_MASK, 32'h0);
    do_read(KEY_REG_IRQ_MASK, d, v, e);
    checks++;
    if (d !== 32'd0 || e !== 1'b0 || v !== 1'b1) begin
      failures++;
      $display("FAIL mask_readback data=%h err=%b required 0/0", d, e);
    end
    settle(10);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v, e;
    key_n[1] = 1'b0;
    repeat (4) tick();
    bus.rd_en = 1'b1;
    bus.addr  = KEY_REG_LEVEL;
    rst       = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    rst       = 1'b1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_read valid=%b data=%h required 0/0",
               bus.rd_valid, bus.rd_data);
    end
    do_read(KEY_REG_COUNT, d, v, e);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_count got=%h required 0", d);
    end
    repeat (10) tick();
    do_read(KEY_REG_PRESSED, d, v, e);
    checks++;
    if (d !== 32'h2 || d !== m_data) begin
      failures++;
      $display("FAIL reset_mid_repress got=%h required 2", d);
    end
    settle(10);
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        key_n = NK'($urandom);
        hold  = $urandom_range(1, 9);
      end
      hold--;
      bus.rd_en   = 1'($urandom_range(0, 1));
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.addr    = 3'($urandom_range(0, 7));
      bus.wr_data = $urandom;
      tick();
      checks++;
      if (bus.rd_valid !== m_valid || bus.rd_data !== m_data ||
          bus.addr_err !== m_err || irq !== m_irq) begin
        failures++;
        $display("FAIL random cyc=%0d valid=%b data=%h err=%b irq=%b required %b/%h/%b/%b",
                 i, bus.rd_valid, bus.rd_data, bus.addr_err, irq,
                 m_valid, m_data, m_err, m_irq);
      end
    end
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    model_reset();
    test_reset();
    test_debounce();
    test_w1c_race();
    test_saturation();
    test_unmapped();
    test_rw_same();
    test_irq();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_mmio_peripheral.md
Name: key_mmio_peripheral

Overview:
- Memory-mapped input peripheral for the four board push-buttons. It sits upstream of the processor's load path in the KEY address window.
- Replaces raw KEY sampling with synchronized, debounced levels, sticky press/release flags and a press counter.
- Reads have 1-cycle registered latency, so data is valid by the processor's UPDATE state (read issued in MEM_ACCESS).

Parameters:
- NUM_KEYS, 4, number of push-buttons (1..8).
- DEBOUNCE_CYCLES, 250000, cycles a synchronized level must hold before it is accepted (5 ms at 50 MHz); must be >= 2.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset, sampled on posedge clk.
- key_n  in  NUM_KEYS  raw board buttons, active-low, asynchronous.
- rd_en  in  1  read strobe, one cycle.
- wr_en  in  1  write strobe, one cycle.
- addr  in  3  word register index.
- wr_data  in  32  write data.
- rd_data  out  32  registered read data.
- rd_valid  out  1  high the cycle after an accepted rd_en.
- addr_err  out  1  one-cycle pulse when rd_en/wr_en targets an unmapped index.
- irq  out  1  interrupt level (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): rd_data=0, rd_valid=0, addr_err=0, irq=0. Synchronizers load 1 (released). Stable levels=released, counters=0, PRESSED=0, RELEASED=0, PRESS_COUNT=0.
- Input path: 2-flop synchronizer per key, then invert, so pressed = 1.
- Debounce, per key:
  - sync==stable: counter<=0.
  - Otherwise counter increments; when counter==DEBOUNCE_CYCLES-1, stable<=sync and counter<=0.
  - A glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
  - Latency from key_n edge to stable change: 2+DEBOUNCE_CYCLES cycles.
- Edges: rise of stable sets PRESSED[k]; fall sets RELEASED[k]. Each rise increments PRESS_COUNT.
- Register map (addr):
  - 0 LEVEL: RO, stable[NUM_KEYS-1:0], zero-extended.
  - 1 PRESSED: W1C.
  - 2 RELEASED: W1C.
  - 3 PRESS_COUNT: 16-bit, saturates at 0xFFFF. Any write clears it to 0.
  - 4 IRQ_MASK: RW, NUM_KEYS bits.
  - 5..7: unmapped.
- Writes take effect at the same posedge.
- Simultaneous W1C and new edge on the same bit: the set wins (flag stays 1).
- Simultaneous counter clear-write and press edge: the counter ends at 1.
- Several keys rising in the same cycle: count increments by the number of rises, still saturating.
- Read:
  - rd_en at cycle N: rd_data/rd_valid are valid at N+1 and reflect register state before any write in cycle N.
  - Reads have no side effects.
  - Unmapped read: rd_data=0, addr_err=1 at N+1.
- rd_data holds its last value when rd_valid=0.
- rd_en and wr_en together to the same address: both are performed; the read returns the pre-write value.
- Reset asserted mid-debounce or mid-read: all state returns to reset values at that posedge, and no rd_valid is produced for the interrupted read.

Optional Feature:
- Macro KEY_MMIO_IRQ_EN.
- Defined: irq = |(PRESSED & IRQ_MASK), registered (asserts one cycle after the flag sets). It deasserts one cycle after W1C clears the flag or the mask bit clears.
- Undefined:
  - irq is tied to 0.
  - IRQ_MASK reads 0 and writes to it are ignored.
  - addr 4 remains mapped, so addr_err is not raised for it.

Decomposition:
- Package key_mmio_pkg:
  - Register index constants KEY_REG_LEVEL=0, KEY_REG_PRESSED=1, KEY_REG_RELEASED=2, KEY_REG_COUNT=3, KEY_REG_IRQ_MASK=4.
  - Count width 16.
- Sub-module key_debounce: one instance per key, containing synchronizer, counter and stable level. It outputs stable, rise and fall pulses.
- Register file and read mux stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst=0 for 3 cycles with key_n=4'b0000 -> after release, LEVEL reads 0 and rd_valid=1 exactly one cycle after rd_en. irq=0.
- Debounce: drop key_n[2] low for 3 cycles, then high -> LEVEL stays 0, PRESSED=0. Hold it low for 10 cycles -> LEVEL=4'b0100 at 2+4 cycles after the edge; PRESSED=4'b0100, PRESS_COUNT=1.
- W1C race: write PRESSED=4'b0001 in the same cycle key0's rise is accepted -> PRESSED[0] remains 1. Write 4'b0001 again later -> 0.
- Saturation: preload PRESS_COUNT to 0xFFFE via presses (or force), press keys 0 and 1 simultaneously -> count=0xFFFF. Write any value to addr 3 -> reads 0.
- Unmapped access: read addr 6 -> rd_data=0, addr_err=1 for one cycle; other registers unchanged.
- IRQ (KEY_MMIO_IRQ_EN defined): IRQ_MASK=4'b1000, press key3 -> irq=1 one cycle after PRESSED[3] sets. W1C PRESSED=4'b1000 -> irq=0 next cycle. With the macro undefined, irq stays 0 and IRQ_MASK reads 0.
